// File: rtl/shared_ram_arb_pkg.sv
// Shared RAM arbiter package: CPU-side FSM state type and RAM lane geometry.
package shared_ram_arb_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StResp = 1'b1
    } cpu_state_e;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;

endpackage

// File: rtl/shared_ram_arb.sv
// Shared RAM arbiter: one 32-bit single-port RAM (four 8-bit lanes) shared by a
// USB byte port that is never stalled and a CPU word port that waits for free
// cycles.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_cpu_valid/addr/wdata/wstrb CPU request (wstrb == 0 means read), held until ready
//   o_cpu_ready, o_cpu_rdata     one-cycle completion pulse and read word
//   i_usb_ren/wen/addr/wdata     USB byte access strobes, address and write byte
//   o_usb_rdata                  USB read byte, valid the cycle after i_usb_ren
//   o_ram_ce/addr/wdata/we       RAM control, word address, write word, lane enables
//   i_ram_rdata                  registered RAM output, valid one cycle after ce
//   o_cpu_stall_cnt              saturating blocked-cycle count of the current request
//   o_cpu_starve                 sticky: stall count reached STARVE_LIMIT
module shared_ram_arb
    import shared_ram_arb_pkg::*;
#(
    parameter int unsigned AW           = 10,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cpu_valid,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [31:0]   i_cpu_wdata,
    input  logic [3:0]    i_cpu_wstrb,
    output logic          o_cpu_ready,
    output logic [31:0]   o_cpu_rdata,
    input  logic          i_usb_ren,
    input  logic          i_usb_wen,
    input  logic [AW-1:0] i_usb_addr,
    input  logic [7:0]    i_usb_wdata,
    output logic [7:0]    o_usb_rdata,
    output logic          o_ram_ce,
    output logic [AW-3:0] o_ram_addr,
    output logic [31:0]   o_ram_wdata,
    output logic [3:0]    o_ram_we,
    input  logic [31:0]   i_ram_rdata,
    output logic [7:0]    o_cpu_stall_cnt,
    output logic          o_cpu_starve
);

    localparam logic [7:0] StarveCnt = 8'(STARVE_LIMIT);

    cpu_state_e state_q, state_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       starve_q, starve_d;
    logic [1:0] lane_sel_q;

    logic usb_acc;
    logic cpu_grant;
    logic cpu_block;

    // CPU addresses are word aligned; the byte offset is ignored.
    logic unused_cpu_addr;
    assign unused_cpu_addr = ^i_cpu_addr[1:0];

    assign usb_acc = i_usb_ren | i_usb_wen;

    // CPU FSM: a grant is only possible from IDLE on a cycle without USB traffic.
    always_comb begin
        state_d   = state_q;
        cpu_grant = 1'b0;
        cpu_block = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_cpu_valid) begin
                    if (usb_acc) begin
                        cpu_block = 1'b1;
                    end else begin
                        cpu_grant = 1'b1;
                        state_d   = StResp;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Stall count holds across an abandoned request and clears only on a grant.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cpu_grant) begin
            stall_cnt_d = '0;
        end else if (cpu_block && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
        // Compared against the next count so the flag rises together with the count.
        starve_d = starve_q | (stall_cnt_d >= StarveCnt);
    end

    // RAM port mux. USB always wins; idle cycles leave the CPU fields on addr/wdata.
    always_comb begin
        o_ram_ce    = 1'b0;
        o_ram_addr  = i_cpu_addr[AW-1:2];
        o_ram_wdata = i_cpu_wdata;
        o_ram_we    = 4'b0000;
        if (usb_acc) begin
            o_ram_ce    = 1'b1;
            o_ram_addr  = i_usb_addr[AW-1:2];
            o_ram_wdata = {LANES{i_usb_wdata}};
            // ren together with wen is a write
            o_ram_we    = i_usb_wen ? (4'b0001 << i_usb_addr[1:0]) : 4'b0000;
        end else if (cpu_grant) begin
            o_ram_ce = 1'b1;
            o_ram_we = i_cpu_wstrb;
        end
        // Keep the RAM quiet while reset is held, even if USB strobes are active.
        if (i_rst) begin
            o_ram_ce = 1'b0;
            o_ram_we = 4'b0000;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            stall_cnt_q <= '0;
            starve_q    <= 1'b0;
            lane_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            starve_q    <= starve_d;
            if (i_usb_ren) begin
                lane_sel_q <= i_usb_addr[1:0];
            end
        end
    end

    // RAM output is registered, so a USB access in RESP cannot disturb the CPU word.
    assign o_cpu_ready     = (state_q == StResp);
    assign o_cpu_rdata     = i_ram_rdata;
    assign o_usb_rdata     = i_ram_rdata[LANE_W*lane_sel_q +: LANE_W];
    assign o_cpu_stall_cnt = stall_cnt_q;
    assign o_cpu_starve    = starve_q;

endmodule

// File: tb/tb_shared_ram_arb.sv
// Bench for shared_ram_arb: directed vector table, hand sequences for the
// multi-cycle cases, and a random phase checked against a transaction model.
module tb_shared_ram_arb;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_valid;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_wstrb;
    logic          usb_ren, usb_wen;
    logic [AW-1:0] usb_addr;
    logic [7:0]    usb_wdata;
    logic [31:0]   ram_rdata;

    logic          rdy_a, rdy_b, ce_a, ce_b, stv_a, stv_b;
    logic [31:0]   crd_a, crd_b, wd_a, wd_b;
    logic [7:0]    urd_a, urd_b, addr_a, addr_b, cnt_a, cnt_b;
    logic [3:0]    we_a, we_b;

    always #5 clk = ~clk;

    shared_ram_arb #(.AW(AW)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_valid(cpu_valid), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .i_cpu_wstrb(cpu_wstrb), .o_cpu_ready(rdy_a), .o_cpu_rdata(crd_a),
        .i_usb_ren(usb_ren), .i_usb_wen(usb_wen), .i_usb_addr(usb_addr),
        .i_usb_wdata(usb_wdata), .o_usb_rdata(urd_a),
        .o_ram_ce(ce_a), .o_ram_addr(addr_a), .o_ram_wdata(wd_a), .o_ram_we(we_a),
        .i_ram_rdata(ram_rdata), .o_cpu_stall_cnt(cnt_a), .o_cpu_starve(stv_a)
    );

    shared_ram_arb #(.AW(AW), .STARVE_LIMIT(3)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_valid(cpu_valid), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .i_cpu_wstrb(cpu_wstrb), .o_cpu_ready(rdy_b), .o_cpu_rdata(crd_b),
        .i_usb_ren(usb_ren), .i_usb_wen(usb_wen), .i_usb_addr(usb_addr),
        .i_usb_wdata(usb_wdata), .o_usb_rdata(urd_b),
        .o_ram_ce(ce_b), .o_ram_addr(addr_b), .o_ram_wdata(wd_b), .o_ram_we(we_b),
        .i_ram_rdata(ram_rdata), .o_cpu_stall_cnt(cnt_b), .o_cpu_starve(stv_b)
    );

    // Environment RAM: four byte lanes, registered read of the old word.
    logic [31:0] ram [256];
    logic        preload = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        if (i == 0) return 32'h4433_2211;
        return (32'(i) * 32'h0101_0101) ^ 32'h9E37_79B9;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (ce_a) begin
            ram_rdata <= ram[addr_a];
            for (int l = 0; l < 4; l++) begin
                if (we_a[l]) ram[addr_a][8*l +: 8] <= wd_a[8*l +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        usb_ren = 1'b0; usb_wen = 1'b0; usb_addr = '0; usb_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        preload = 1'b1;
        tick();
        preload = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    typedef struct {
        logic          valid;
        logic [AW-1:0] caddr;
        logic [31:0]   cwdata;
        logic [3:0]    cwstrb;
        logic          ren, wen;
        logic [AW-1:0] uaddr;
        logic [7:0]    uwdata;
        logic          e_ce;
        logic [7:0]    e_addr;
        logic [31:0]   e_wdata;
        logic [3:0]    e_we;
    } vec_t;

    vec_t vecs[6];

    // Random-phase model state
    logic [31:0] exp_mem [256];
    bit          m_resp, m_rd_chk, m_urd, m_stv_a, m_stv_b, active, gap;
    logic [31:0] m_rdata;
    logic [7:0]  m_urd_v;
    int          m_stall;

    initial begin
        idle_inputs();
        // Reset: asynchronous, and it silences the RAM even with USB strobes up.
        #1 rst = 1'b1;
        #1 usb_ren = 1'b1; usb_wen = 1'b1; usb_addr = 10'h005;
        #1;
        chk("rst_ce", 64'(ce_a), 64'd0);
        chk("rst_we", 64'(we_a), 64'd0);
        chk("rst_ready", 64'(rdy_a), 64'd0);
        chk("rst_cnt", 64'(cnt_a), 64'd0);
        chk("rst_starve", 64'(stv_a), 64'd0);
        do_reset();

        // Single-cycle RAM mux vectors, applied from IDLE.
        vecs[0] = '{1'b0, 10'h3FC, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 10'h000, 8'h00,
                    1'b0, 8'hFF, 32'h1234_5678, 4'h0};
        vecs[1] = '{1'b0, 10'h000, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 10'h007, 8'hA5,
                    1'b1, 8'h01, 32'hA5A5_A5A5, 4'b1000};
        vecs[2] = '{1'b0, 10'h20C, 32'h0BAD_F00D, 4'h3, 1'b1, 1'b0, 10'h002, 8'h3C,
                    1'b1, 8'h00, 32'h3C3C_3C3C, 4'b0000};
        vecs[3] = '{1'b0, 10'h000, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 10'h105, 8'h7E,
                    1'b1, 8'h41, 32'h7E7E_7E7E, 4'b0010};
        vecs[4] = '{1'b1, 10'h010, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 10'h3FF, 8'h11,
                    1'b1, 8'hFF, 32'h1111_1111, 4'b1000};
        vecs[5] = '{1'b1, 10'h0A8, 32'hCAFE_F00D, 4'b0101, 1'b0, 1'b0, 10'h000, 8'h00,
                    1'b1, 8'h2A, 32'hCAFE_F00D, 4'b0101};
        for (int i = 0; i < 6; i++) begin
            cpu_valid = vecs[i].valid; cpu_addr = vecs[i].caddr;
            cpu_wdata = vecs[i].cwdata; cpu_wstrb = vecs[i].cwstrb;
            usb_ren = vecs[i].ren; usb_wen = vecs[i].wen;
            usb_addr = vecs[i].uaddr; usb_wdata = vecs[i].uwdata;
            #1;
            chk($sformatf("vec%0d_ce", i), 64'(ce_a), 64'(vecs[i].e_ce));
            chk($sformatf("vec%0d_addr", i), 64'(addr_a), 64'(vecs[i].e_addr));
            chk($sformatf("vec%0d_wdata", i), 64'(wd_a), 64'(vecs[i].e_wdata));
            chk($sformatf("vec%0d_we", i), 64'(we_a), 64'(vecs[i].e_we));
            tick();
            idle_inputs();
            tick();
        end

        // CPU read of the preloaded word, no USB traffic: two-cycle latency.
        do_reset();
        cpu_valid = 1'b1; cpu_addr = 10'h010;
        #1;
        chk("rd_ce", 64'(ce_a), 64'd1);
        chk("rd_addr", 64'(addr_a), 64'h04);
        chk("rd_we", 64'(we_a), 64'd0);
        chk("rd_ready_early", 64'(rdy_a), 64'd0);
        tick();
        chk("rd_ready", 64'(rdy_a), 64'd1);
        chk("rd_data", 64'(crd_a), 64'hDEAD_BEEF);
        cpu_valid = 1'b0;
        tick();
        chk("rd_ready_pulse", 64'(rdy_a), 64'd0);

        // Five cycles of USB reads block the CPU; starve trips at 3 in dut_b.
        do_reset();
        cpu_valid = 1'b1; cpu_addr = 10'h010; usb_ren = 1'b1; usb_addr = 10'h100;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("blk%0d_addr", i), 64'(addr_a), 64'h40);
            tick();
            chk($sformatf("blk%0d_cnt", i), 64'(cnt_a), 64'(i));
            chk($sformatf("blk%0d_ready", i), 64'(rdy_a), 64'd0);
            chk($sformatf("blk%0d_starve3", i), 64'(stv_b), (i >= 3) ? 64'd1 : 64'd0);
            chk($sformatf("blk%0d_starve64", i), 64'(stv_a), 64'd0);
        end
        usb_ren = 1'b0;
        #1;
        chk("blk_grant_ce", 64'(ce_a), 64'd1);
        chk("blk_grant_addr", 64'(addr_a), 64'h04);
        chk("blk_cnt_hold", 64'(cnt_a), 64'd5);
        tick();
        chk("blk_ready", 64'(rdy_a), 64'd1);
        chk("blk_cnt_clr", 64'(cnt_a), 64'd0);
        chk("blk_data", 64'(crd_a), 64'hDEAD_BEEF);
        cpu_valid = 1'b0;
        tick();
        chk("blk_starve_sticky", 64'(stv_b), 64'd1);

        // USB byte reads, alone and coinciding with a CPU response cycle.
        do_reset();
        usb_ren = 1'b1; usb_addr = 10'h002;
        tick();
        usb_addr = 10'h003;
        chk("usb_rd_lane2", 64'(urd_a), 64'h33);
        tick();
        usb_ren = 1'b0;
        chk("usb_rd_lane3", 64'(urd_a), 64'h44);
        cpu_valid = 1'b1; cpu_addr = 10'h010;
        tick();
        usb_ren = 1'b1; usb_addr = 10'h002;
        #1;
        chk("resp_usb_ce", 64'(ce_a), 64'd1);
        chk("resp_usb_addr", 64'(addr_a), 64'h00);
        chk("resp_ready", 64'(rdy_a), 64'd1);
        chk("resp_data", 64'(crd_a), 64'hDEAD_BEEF);
        tick();
        usb_ren = 1'b0; cpu_valid = 1'b0;
        chk("resp_usb_rd", 64'(urd_a), 64'h33);
        chk("resp_ready_clr", 64'(rdy_a), 64'd0);

        // Reset between edges during RESP drops ready immediately.
        do_reset();
        cpu_valid = 1'b1; cpu_addr = 10'h010;
        tick();
        chk("mid_ready", 64'(rdy_a), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(rdy_a), 64'd0);
        cpu_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_post_ready", 64'(rdy_a), 64'd0);
        tick();
        chk("mid_idle_ready", 64'(rdy_a), 64'd0);
        cpu_valid = 1'b1;
        #1;
        chk("mid_regrant_ce", 64'(ce_a), 64'd1);
        tick();
        chk("mid_regrant_ready", 64'(rdy_a), 64'd1);
        cpu_valid = 1'b0;
        tick();

        // Long block: starve at 64 in dut_a, count saturates at 255.
        do_reset();
        cpu_valid = 1'b1; cpu_addr = 10'h010; usb_ren = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (i == 63) chk("sat_starve63", 64'(stv_a), 64'd0);
            if (i == 64) chk("sat_starve64", 64'(stv_a), 64'd1);
            if (i == 255 || i == 260) chk($sformatf("sat_cnt%0d", i), 64'(cnt_a), 64'd255);
        end
        idle_inputs();
        tick();

        // Abandoned request keeps its stall count until the next grant.
        do_reset();
        cpu_valid = 1'b1; cpu_addr = 10'h010; usb_wen = 1'b1; usb_addr = 10'h3F0;
        tick();
        tick();
        chk("abn_cnt", 64'(cnt_a), 64'd2);
        cpu_valid = 1'b0; usb_wen = 1'b0;
        tick(); tick(); tick();
        chk("abn_cnt_hold", 64'(cnt_a), 64'd2);
        chk("abn_ready", 64'(rdy_a), 64'd0);
        chk("abn_ce", 64'(ce_a), 64'd0);
        cpu_valid = 1'b1;
        tick();
        chk("abn_grant_cnt", 64'(cnt_a), 64'd0);
        chk("abn_grant_ready", 64'(rdy_a), 64'd1);
        cpu_valid = 1'b0;
        tick();

        // Random traffic against a transaction-level model of memory and arbitration.
        do_reset();
        for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
        m_resp = 0; m_rd_chk = 0; m_urd = 0; m_stv_a = 0; m_stv_b = 0;
        active = 0; gap = 0; m_stall = 0; m_rdata = '0; m_urd_v = '0;
        for (int n = 0; n < 2000; n++) begin
            logic       usb, grant, e_ce;
            logic [7:0] e_addr;
            logic [31:0] e_wd;
            logic [3:0] e_we;
            int         r, w, ln;
            if (m_resp) begin
                // requester holds valid through the response cycle
            end else if (gap) begin
                cpu_valid = 1'b0; gap = 0;
            end else if (!active) begin
                if ($urandom_range(2) == 0) begin
                    active = 1; cpu_valid = 1'b1;
                    cpu_addr = 10'($urandom); cpu_wdata = $urandom;
                    cpu_wstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
                end
            end else if ($urandom_range(15) == 0) begin
                active = 0; cpu_valid = 1'b0;
            end
            r = $urandom_range(9);
            usb_ren = (r < 3) || (r == 5);
            usb_wen = (r == 3) || (r == 4) || (r == 5);
            usb_addr = 10'($urandom); usb_wdata = 8'($urandom);

            usb    = usb_ren | usb_wen;
            grant  = !m_resp && cpu_valid && !usb;
            e_ce   = usb || grant;
            e_addr = usb ? usb_addr[9:2] : cpu_addr[9:2];
            e_wd   = usb ? {4{usb_wdata}} : cpu_wdata;
            e_we   = usb ? (usb_wen ? 4'(1 << usb_addr[1:0]) : 4'h0)
                         : (grant ? cpu_wstrb : 4'h0);
            #1;
            chk("rnd_ram_a", {19'd0, ce_a, we_a, addr_a, wd_a}, {19'd0, e_ce, e_we, e_addr, e_wd});
            chk("rnd_ram_b", {19'd0, ce_b, we_b, addr_b, wd_b}, {19'd0, e_ce, e_we, e_addr, e_wd});
            chk("rnd_ready", {rdy_a, rdy_b}, {m_resp, m_resp});
            if (m_resp && m_rd_chk) chk("rnd_cpu_rdata", {crd_a, crd_b}, {m_rdata, m_rdata});
            if (m_urd) chk("rnd_usb_rdata", {urd_a, urd_b}, {m_urd_v, m_urd_v});
            chk("rnd_cnt", {cnt_a, cnt_b}, {8'(m_stall), 8'(m_stall)});
            chk("rnd_starve", {stv_a, stv_b}, {m_stv_a, m_stv_b});

            w  = int'(usb_addr[9:2]);
            ln = int'(usb_addr[1:0]);
            m_urd = usb_ren && !usb_wen;
            if (m_urd) m_urd_v = exp_mem[w][8*ln +: 8];
            if (usb_wen) exp_mem[w][8*ln +: 8] = usb_wdata;
            if (m_resp) begin
                m_resp = 0; active = 0; gap = 1;
            end else if (cpu_valid) begin
                if (usb) begin
                    m_stall = (m_stall < 255) ? m_stall + 1 : 255;
                end else begin
                    w = int'(cpu_addr[9:2]);
                    m_resp = 1; m_rd_chk = (cpu_wstrb == 4'h0);
                    m_rdata = exp_mem[w];
                    for (int l = 0; l < 4; l++) begin
                        if (cpu_wstrb[l]) exp_mem[w][8*l +: 8] = cpu_wdata[8*l +: 8];
                    end
                    m_stall = 0;
                end
            end
            if (m_stall >= 64) m_stv_a = 1;
            if (m_stall >= 3)  m_stv_b = 1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_ram_arb.md
SHARED_RAM_ARB -- requirements
Module: shared_ram_arb

Interface
REQ-001 Parameter AW, default 10, is the byte-address width of the shared RAM; word address = AW-2 bits.
REQ-002 Parameter STARVE_LIMIT, default 64, is the blocked-cycle count at which o_cpu_starve asserts; range 1..255.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 i_clk  in  1  clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  asynchronous active-high reset.
REQ-006 i_cpu_valid  in  1  CPU request; held until ready.
REQ-007 i_cpu_addr  in  AW  CPU byte address; bits [1:0] ignored.
REQ-008 i_cpu_wdata  in  32  CPU write word.
REQ-009 i_cpu_wstrb  in  4  byte enables; 0 = read.
REQ-010 o_cpu_ready  out  1  one-cycle completion pulse.
REQ-011 o_cpu_rdata  out  32  read word; valid when o_cpu_ready=1.
REQ-012 i_usb_ren / i_usb_wen  in  1 each  USB byte read/write strobe; never stalled.
REQ-013 i_usb_addr  in  AW  USB byte address.
REQ-014 i_usb_wdata  in  8  USB write byte.
REQ-015 o_usb_rdata  out  8  read byte; valid the cycle after i_usb_ren.
REQ-016 o_ram_ce  out  1;  o_ram_addr  out  AW-2;  o_ram_wdata  out  32;  o_ram_we  out  4  -- drive four 8-bit synchronous single-port lanes.
REQ-017 i_ram_rdata  in  32  RAM output; registered, valid one cycle after o_ram_ce.
REQ-018 o_cpu_stall_cnt  out  8  saturating count of blocked CPU cycles in the current request.
REQ-019 o_cpu_starve  out  1  sticky flag: stall count reached STARVE_LIMIT.

Function
REQ-020 USB access (ren|wen) SHALL own the RAM unconditionally that cycle: ce=1, addr=i_usb_addr[AW-1:2], wdata={4{i_usb_wdata}}, we=wen<<i_usb_addr[1:0].
REQ-021 CPU FSM SHALL have states IDLE and RESP.
REQ-022 In IDLE with i_cpu_valid=1 and no USB access: RAM driven with CPU addr[AW-1:2], wdata, wstrb, ce=1; next state RESP.
REQ-023 In IDLE with i_cpu_valid=1 and a USB access: CPU blocked, state stays IDLE, o_cpu_stall_cnt increments (saturating at 255).
REQ-024 In RESP: o_cpu_ready=1, o_cpu_rdata=i_ram_rdata; next state IDLE unconditionally; CPU latency = 2 cycles from unblocked valid.
REQ-025 A USB access during RESP SHALL be served; o_cpu_rdata is unaffected, since RAM output updates only at the following edge.
REQ-026 o_cpu_stall_cnt SHALL clear on the cycle the CPU is granted (IDLE->RESP).
REQ-027 o_cpu_starve SHALL set when o_cpu_stall_cnt reaches STARVE_LIMIT and hold until reset.
REQ-028 The block SHALL register i_usb_addr[1:0] on every i_usb_ren; o_usb_rdata = lane [8*sel+7:8*sel] of i_ram_rdata.
REQ-029 With no access: o_ram_ce=0 and o_ram_we=0; o_ram_addr and o_ram_wdata are don't-care but deterministic (CPU fields).
REQ-030 i_usb_ren and i_usb_wen both high SHALL be treated as a write with ce=1.
REQ-031 i_cpu_valid dropping in IDLE without a grant SHALL abandon the request silently; the stall count holds until the next grant.
REQ-032 The requester SHALL deassert i_cpu_valid the cycle after o_cpu_ready; the FSM never issues a grant from RESP.

Reset
REQ-033 Asserting i_rst SHALL force: state IDLE, o_cpu_ready=0, o_cpu_stall_cnt=0, o_cpu_starve=0, lane select=0, o_ram_ce=0, o_ram_we=0, immediately and independent of i_clk.
REQ-034 Reset in RESP SHALL drop o_cpu_ready at once; the pending CPU transfer is lost.

Structure
REQ-035 Package shared_ram_arb_pkg SHALL hold the FSM state enum, LANES=4 and LANE_W=8.
REQ-036 The block is a single module; no sub-module is required.

Verification
REQ-037 CPU read 0x010, no USB -> ce at T0, o_cpu_ready at T1 with the preloaded word 0xDEADBEEF.
REQ-038 USB ren continuous for 5 cycles while CPU valid -> no CPU grant, o_cpu_stall_cnt=5, then grant on the first free cycle and cnt=0.
REQ-039 USB wen addr 0x0007, data 0xA5 -> o_ram_we=4'b1000, o_ram_wdata=0xA5A5A5A5, o_ram_addr=0x01.
REQ-040 USB ren at 0x0002 with RAM word 0x44332211 -> o_usb_rdata=0x33 next cycle, including when a CPU RESP coincides.
REQ-041 STARVE_LIMIT=3, USB busy for 4 cycles with CPU valid -> o_cpu_starve=1 at count 3, stays 1 after the grant.
REQ-042 i_rst asserted mid-RESP between clock edges -> o_cpu_ready=0 before the next edge, state IDLE.
